// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: types and constants shared by the D-memory port arbiter.
//   owner_t      - who holds (or last held) the SRAM port
//   MAX_WAIT_DEF - default starvation bound / locked-burst length for port B
//   cnt_w()      - width of a counter that must hold 0..max
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  localparam int MAX_WAIT_DEF = 4;

  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_sat_counter.sv
// sat_counter: up-counter that saturates at MAX.
//   CLK  - clock
//   RSTn - synchronous active-low reset (count -> 0)
//   clr  - synchronous clear, wins over inc
//   inc  - increment by one, holds at MAX
//   cnt  - current count
module sat_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge CLK) begin
    if (!RSTn)                      cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (inc && cnt < W'(MAX))  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-port data SRAM between port A (CPU
// load/store, fixed priority) and port B (debug/loader). B is guaranteed a
// grant after MAX_WAIT denied cycles and may hold the port for up to MAX_WAIT
// consecutive beats with B_LOCK. Read data comes back one cycle after grant.
//   CLK, RSTn                    - clock, synchronous active-low reset
//   {A,B}_REQ/WEN/BE/ADDR/DI     - requests (WEN: 1 = read, 0 = write)
//   B_LOCK                       - B asks to keep the port for the next beat
//   {A,B}_GNT                    - combinational grant
//   {A,B}_RVALID/RDATA           - registered read response (RDATA 0 unless valid)
//   MEM_CSN/WEN/BE/ADDR/DOUT     - SRAM control/write side (CSN, WEN active-low)
//   MEM_DI                       - SRAM read data (valid the cycle after a read)
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AWIDTH   = 12,
  parameter int DWIDTH   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              A_REQ,
  input  logic              A_WEN,
  input  logic [3:0]        A_BE,
  input  logic [AWIDTH-1:0] A_ADDR,
  input  logic [DWIDTH-1:0] A_DI,
  input  logic              B_REQ,
  input  logic              B_WEN,
  input  logic [3:0]        B_BE,
  input  logic [AWIDTH-1:0] B_ADDR,
  input  logic [DWIDTH-1:0] B_DI,
  input  logic              B_LOCK,
  output logic              A_GNT,
  output logic              B_GNT,
  output logic              A_RVALID,
  output logic              B_RVALID,
  output logic [DWIDTH-1:0] A_RDATA,
  output logic [DWIDTH-1:0] B_RDATA,
  output logic              MEM_CSN,
  output logic              MEM_WEN,
  output logic [3:0]        MEM_BE,
  output logic [AWIDTH-1:0] MEM_ADDR,
  output logic [DWIDTH-1:0] MEM_DOUT,
  input  logic [DWIDTH-1:0] MEM_DI
);

  localparam int            CW   = cnt_w(MAX_WAIT);
  localparam logic [CW-1:0] CMAX = CW'(MAX_WAIT);

  owner_t        gnt_owner, last_owner, rd_owner;
  logic [CW-1:0] wait_b, burst_b;
  logic          wait_inc, wait_clr;

  // Grant priority: starvation rescue, then B's locked burst, then A, then B.
  always_comb begin
    gnt_owner = OWN_NONE;
    if (!RSTn)                                                     gnt_owner = OWN_NONE;
    else if (B_REQ && wait_b == CMAX)                              gnt_owner = OWN_B;
    else if (B_REQ && B_LOCK && last_owner == OWN_B && burst_b < CMAX) gnt_owner = OWN_B;
    else if (A_REQ)                                                gnt_owner = OWN_A;
    else if (B_REQ)                                                gnt_owner = OWN_B;
  end

  assign A_GNT = (gnt_owner == OWN_A);
  assign B_GNT = (gnt_owner == OWN_B);

  // SRAM side is parked (deselected, all zeros) whenever nobody is granted.
  always_comb begin
    MEM_CSN  = 1'b1;
    MEM_WEN  = 1'b1;
    MEM_BE   = '0;
    MEM_ADDR = '0;
    MEM_DOUT = '0;
    unique case (gnt_owner)
      OWN_A: begin
        MEM_CSN  = 1'b0;
        MEM_WEN  = A_WEN;
        MEM_BE   = A_BE;
        MEM_ADDR = A_ADDR;
        MEM_DOUT = A_DI;
      end
      OWN_B: begin
        MEM_CSN  = 1'b0;
        MEM_WEN  = B_WEN;
        MEM_BE   = B_BE;
        MEM_ADDR = B_ADDR;
        MEM_DOUT = B_DI;
      end
      default: ;
    endcase
  end

  // rd_owner tags whose read is on MEM_DI this cycle; writes get no response.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      last_owner <= OWN_NONE;
      rd_owner   <= OWN_NONE;
    end else begin
      last_owner <= gnt_owner;
      if (A_GNT && A_WEN)      rd_owner <= OWN_A;
      else if (B_GNT && B_WEN) rd_owner <= OWN_B;
      else                     rd_owner <= OWN_NONE;
    end
  end

  assign A_RVALID = (rd_owner == OWN_A);
  assign B_RVALID = (rd_owner == OWN_B);
  assign A_RDATA  = A_RVALID ? MEM_DI : '0;
  assign B_RDATA  = B_RVALID ? MEM_DI : '0;

  // wait_b: cycles B has been requesting without a grant.
  assign wait_inc = B_REQ & ~B_GNT;
  assign wait_clr = B_GNT | ~B_REQ;

  sat_counter #(.MAX(MAX_WAIT), .W(CW)) u_wait_b (
    .CLK  (CLK),
    .RSTn (RSTn),
    .inc  (wait_inc),
    .clr  (wait_clr),
    .cnt  (wait_b)
  );

  // burst_b: consecutive B grants; any cycle without a B grant ends the run.
  sat_counter #(.MAX(MAX_WAIT), .W(CW)) u_burst_b (
    .CLK  (CLK),
    .RSTn (RSTn),
    .inc  (B_GNT),
    .clr  (~B_GNT),
    .cnt  (burst_b)
  );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed plan scenarios followed by randomized traffic,
// all checked against a transaction-level model of the arbiter plus a
// reference copy of memory kept inside the bench.
module tb_dmem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          A_REQ, A_WEN, B_REQ, B_WEN, B_LOCK;
  logic [3:0]    A_BE, B_BE;
  logic [AW-1:0] A_ADDR, B_ADDR;
  logic [DW-1:0] A_DI, B_DI;
  logic          A_GNT, B_GNT, A_RVALID, B_RVALID;
  logic [DW-1:0] A_RDATA, B_RDATA;
  logic          MEM_CSN, MEM_WEN;
  logic [3:0]    MEM_BE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_DOUT, MEM_DI;

  always #5 CLK = ~CLK;

  dmem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_WAIT(MW)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .A_REQ(A_REQ), .A_WEN(A_WEN), .A_BE(A_BE), .A_ADDR(A_ADDR), .A_DI(A_DI),
    .B_REQ(B_REQ), .B_WEN(B_WEN), .B_BE(B_BE), .B_ADDR(B_ADDR), .B_DI(B_DI),
    .B_LOCK(B_LOCK),
    .A_GNT(A_GNT), .B_GNT(B_GNT), .A_RVALID(A_RVALID), .B_RVALID(B_RVALID),
    .A_RDATA(A_RDATA), .B_RDATA(B_RDATA),
    .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_BE(MEM_BE), .MEM_ADDR(MEM_ADDR),
    .MEM_DOUT(MEM_DOUT), .MEM_DI(MEM_DI)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // SRAM behavioural model (environment, driven by the DUT's MEM_* pins).
  logic [31:0] sram    [1024];
  logic [31:0] ref_mem [1024];

  always @(posedge CLK) begin
    if (!MEM_CSN) begin
      if (!MEM_WEN) sram[MEM_ADDR[11:2]] <= merge(sram[MEM_ADDR[11:2]], MEM_DOUT, MEM_BE);
      else          MEM_DI <= sram[MEM_ADDR[11:2]];
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: waiting time of B, length of B's current run of grants,
  // who had the port last cycle, and the read response due this cycle.
  int          m_wait, m_burst, m_last;   // m_last: 0 none, 1 A, 2 B
  bit          e_rva, e_rvb;
  logic [31:0] e_rd;
  int          last_g;
  logic        obs_ga, obs_gb;

  task automatic model_reset();
    m_wait = 0; m_burst = 0; m_last = 0;
    e_rva = 0; e_rvb = 0; e_rd = '0;
  endtask

  function automatic int pick();
    if (!RSTn)                                          return 0;
    if (B_REQ && m_wait >= MW)                          return 2;
    if (B_REQ && B_LOCK && m_last == 2 && m_burst < MW) return 2;
    if (A_REQ)                                          return 1;
    if (B_REQ)                                          return 2;
    return 0;
  endfunction

  // One clock: predict, check at negedge, advance model at posedge.
  task automatic cyc();
    int g;
    g = pick();
    @(negedge CLK);
    chk("a_gnt", A_GNT, g == 1);
    chk("b_gnt", B_GNT, g == 2);
    chk("mem_csn",  MEM_CSN,  g == 0);
    chk("mem_wen",  MEM_WEN,  g == 1 ? A_WEN  : g == 2 ? B_WEN  : 1'b1);
    chk("mem_be",   MEM_BE,   g == 1 ? A_BE   : g == 2 ? B_BE   : 4'h0);
    chk("mem_addr", MEM_ADDR, g == 1 ? A_ADDR : g == 2 ? B_ADDR : 12'h0);
    chk("mem_dout", MEM_DOUT, g == 1 ? A_DI   : g == 2 ? B_DI   : 32'h0);
    chk("a_rvalid", A_RVALID, e_rva);
    chk("b_rvalid", B_RVALID, e_rvb);
    chk("a_rdata",  A_RDATA,  e_rva ? e_rd : 32'h0);
    chk("b_rdata",  B_RDATA,  e_rvb ? e_rd : 32'h0);
    obs_ga = A_GNT; obs_gb = B_GNT; last_g = g;
    @(posedge CLK);
    if (!RSTn) model_reset();
    else begin
      e_rva = (g == 1) && A_WEN;
      e_rvb = (g == 2) && B_WEN;
      if (g == 1) begin
        if (A_WEN) e_rd = ref_mem[A_ADDR[11:2]];
        else       ref_mem[A_ADDR[11:2]] = merge(ref_mem[A_ADDR[11:2]], A_DI, A_BE);
      end else if (g == 2) begin
        if (B_WEN) e_rd = ref_mem[B_ADDR[11:2]];
        else       ref_mem[B_ADDR[11:2]] = merge(ref_mem[B_ADDR[11:2]], B_DI, B_BE);
      end
      m_wait  = (B_REQ && g != 2) ? ((m_wait + 1 > MW) ? MW : m_wait + 1) : 0;
      m_burst = (g == 2) ? ((m_burst + 1 > MW) ? MW : m_burst + 1) : 0;
      m_last  = g;
    end
    #1;
  endtask

  task automatic new_a();
    A_REQ  = ($urandom_range(0, 3) != 0);
    A_WEN  = 1'($urandom_range(0, 1));
    A_BE   = 4'($urandom);
    A_ADDR = AW'($urandom_range(0, 31) << 2);
    A_DI   = $urandom;
  endtask

  task automatic new_b();
    B_REQ  = ($urandom_range(0, 1) != 0);
    B_LOCK = ($urandom_range(0, 2) != 0);
    B_WEN  = 1'($urandom_range(0, 1));
    B_BE   = 4'($urandom);
    B_ADDR = AW'($urandom_range(0, 31) << 2);
    B_DI   = $urandom;
  endtask

  task automatic idle();
    A_REQ = 0; A_WEN = 1; A_BE = 4'hF; A_ADDR = '0; A_DI = '0;
    B_REQ = 0; B_WEN = 1; B_BE = 4'hF; B_ADDR = '0; B_DI = '0; B_LOCK = 0;
  endtask

  initial begin
    logic [31:0] w;
    logic [5:0]  t3_exp;
    int          beat;
    for (int i = 0; i < 1024; i++) begin
      w = $urandom; sram[i] = w; ref_mem[i] = w;
    end
    sram[4] = 32'h0000_0EEC; ref_mem[4] = 32'h0000_0EEC;   // byte addr 0x010
    sram[8] = 32'h0;         ref_mem[8] = 32'h0;           // byte addr 0x020
    MEM_DI = '0;
    idle();
    RSTn = 0;
    model_reset();
    @(posedge CLK); #1;
    cyc(); cyc();
    RSTn = 1;

    // Idle: nothing selected, nothing returned.
    for (int i = 0; i < 10; i++) cyc();
    chk("idle_csn",  MEM_CSN,  1'b1);
    chk("idle_addr", MEM_ADDR, 12'h0);
    chk("idle_rv",   {A_RVALID, B_RVALID}, 2'b00);

    // A read of 0x010.
    A_REQ = 1; A_WEN = 1; A_ADDR = 12'h010;
    cyc();
    chk("t1_gnt", obs_ga, 1'b1);
    chk("t1_rv",  A_RVALID, 1'b1);
    chk("t1_rd",  A_RDATA, 32'h0000_0EEC);
    chk("t1_brv", B_RVALID, 1'b0);
    A_REQ = 0;
    cyc();

    // Byte write by B, readback by A.
    B_REQ = 1; B_WEN = 0; B_BE = 4'b0010; B_DI = 32'hAABB_CCDD; B_ADDR = 12'h020;
    cyc();
    chk("t4_bgnt", obs_gb, 1'b1);
    idle();
    A_REQ = 1; A_WEN = 1; A_ADDR = 12'h020;
    cyc();
    chk("t4_rd", A_RDATA, 32'h0000_CC00);
    idle();
    cyc();

    // Contention: B gets every fifth slot.
    A_REQ = 1; A_WEN = 1; A_ADDR = 12'h010;
    B_REQ = 1; B_WEN = 1; B_ADDR = 12'h020; B_LOCK = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t2_bgnt", obs_gb, (i % 5) == 4);
    end
    idle();
    cyc(); cyc();

    // Locked burst: four B beats, one A, then B again.
    t3_exp = 6'b101111;
    beat = 1;
    B_REQ = 1; B_LOCK = 1; B_WEN = 0; B_BE = 4'hF; B_ADDR = 12'h040; B_DI = 32'(beat);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t3_bgnt", obs_gb, t3_exp[i]);
      if (obs_gb) begin beat++; B_DI = 32'(beat); end
      if (obs_ga) A_REQ = 0;
      if (i == 0) begin A_REQ = 1; A_WEN = 1; A_ADDR = 12'h010; end
    end
    idle();
    cyc(); cyc();

    // Reset lands on the edge that would have returned a read.
    A_REQ = 1; A_WEN = 1; A_ADDR = 12'h010;
    @(negedge CLK);
    chk("t5_gnt", A_GNT, 1'b1);
    RSTn = 0;
    @(posedge CLK);
    model_reset();
    #1;
    chk("t5_rv", A_RVALID, 1'b0);
    A_REQ = 0;
    cyc();
    RSTn = 1;
    B_REQ = 1; B_WEN = 1; B_ADDR = 12'h010;
    cyc();
    chk("t5_bgnt", obs_gb, 1'b1);
    idle();
    cyc();

    // Randomized traffic with occasional resets.
    new_a(); new_b();
    for (int n = 0; n < 3000; n++) begin
      RSTn = ($urandom_range(0, 299) != 0);
      cyc();
      if (last_g == 1 || !A_REQ) new_a();
      if (last_g == 2 || !B_REQ) new_b();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single-port data SRAM between two requesters: port A (CPU core load/store path) and port B (debug/loader port for preloading and dumping test memory). Port A has fixed priority. Port B has a starvation guarantee and a locked-burst mode for back-to-back loader beats. The block sits between RISCV_TOP's D-memory interface and the SP_SRAM instance and returns read data one cycle after grant, matching the SRAM's synchronous read.

## Interface
- AWIDTH, 12, memory byte-address width
- DWIDTH, 32, data width
- MAX_WAIT, 4, maximum number of cycles B may wait while requesting; also the maximum locked-burst length (≥1)

- CLK  in  1  clock
- RSTn  in  1  reset, synchronous, active-low
- A_REQ / B_REQ  in  1  access request
- A_WEN / B_WEN  in  1  1 = read, 0 = write
- A_BE / B_BE  in  4  byte enables
- A_ADDR / B_ADDR  in  AWIDTH  address
- A_DI / B_DI  in  DWIDTH  write data
- B_LOCK  in  1  request to keep the grant for consecutive beats
- A_GNT / B_GNT  out  1  access accepted this cycle (combinational)
- A_RVALID / B_RVALID  out  1  read data valid (registered)
- A_RDATA / B_RDATA  out  DWIDTH  read data; forced to 0 unless the matching RVALID is 1
- MEM_CSN  out  1  SRAM chip select, active-low
- MEM_WEN  out  1  SRAM write enable, active-low
- MEM_BE  out  4  SRAM byte enables
- MEM_ADDR  out  AWIDTH  SRAM address
- MEM_DOUT  out  DWIDTH  write data to SRAM
- MEM_DI  in  DWIDTH  read data from SRAM

## Operation
- Registered state:
  - last_owner ∈ {NONE, A, B}
  - wait_b counter, 0..MAX_WAIT, saturating
  - burst_b counter, 0..MAX_WAIT
  - rd_owner ∈ {NONE, A, B}, registered as RVALID
- Grant decision each cycle with RSTn=1 (first matching rule wins):
  1. B_REQ & wait_b==MAX_WAIT → B
  2. B_REQ & B_LOCK & last_owner==B & burst_b<MAX_WAIT → B
  3. A_REQ → A
  4. B_REQ → B
  5. otherwise → none
- At most one GNT is high in any cycle.
- MEM_* outputs are muxed from the granted port; MEM_CSN=0 only on a grant.
- With no grant: MEM_CSN=1, MEM_WEN=1, MEM_BE=0, MEM_ADDR=0, MEM_DOUT=0.
- wait_b update:
  - +1 (saturating) when B_REQ & !B_GNT
  - cleared when B_GNT or !B_REQ
- burst_b update:
  - +1 when B_GNT
  - cleared on any cycle without B_GNT
- last_owner ← granted port, or NONE if no grant.
- Reads: a granted read sets the owner's RVALID for exactly the next cycle, with RDATA = MEM_DI in that cycle.
- Writes: complete at the grant edge; no response.
- Request signals are sampled only in the cycle they are presented; a requester holds them until it sees GNT.
- A locked burst ends when B_LOCK drops or B_REQ drops. It is also interrupted after MAX_WAIT beats if A_REQ is high. If A_REQ is low, B continues via rule 4 and burst_b keeps counting (saturating).

## Timing
- Grant latency: 0 cycles (GNT combinational from REQ and state).
- Read latency: 1 cycle from grant to RVALID.
- Back-to-back grants are allowed every cycle, for the same port or alternating ports.
- Worst-case B wait under continuous A_REQ: MAX_WAIT cycles. Grant occurs in cycle MAX_WAIT+1 of the request.
- Simultaneous A_REQ and B_REQ with wait_b<MAX_WAIT and no lock: A wins.
- Reset (RSTn low at a posedge):
  - last_owner=NONE, wait_b=0, burst_b=0, A_RVALID=B_RVALID=0
  - A read granted in the cycle before the reset edge never returns RVALID.
- While RSTn=0: A_GNT=B_GNT=0, MEM_CSN=1, all other MEM_* outputs 0, RDATA 0.

## Structure
- Shared package dmem_arb_pkg:
  - owner_t enum {OWN_NONE, OWN_A, OWN_B}
  - default MAX_WAIT constant
  - counter width = $clog2(MAX_WAIT+1)
- One sub-module, sat_counter (parameterised max; inc/clr inputs; synchronous active-low reset). Instantiated twice, for wait_b and burst_b.
- The grant mux and RDATA routing stay in the top level.

## Test plan
- A read only: A_REQ=1, A_WEN=1, ADDR=0x010, SRAM[0x010]=0x0000_0EEC → A_GNT same cycle, MEM_CSN=0; next cycle A_RVALID=1, A_RDATA=0x0EEC; B_RVALID stays 0.
- Contention: A_REQ and B_REQ held high continuously, MAX_WAIT=4 → grants A,A,A,A,B,A,A,A,A,B…; B is never denied more than 4 cycles.
- Locked burst: B_REQ=B_LOCK=1 writing 0x1,0x2,…; A_REQ raised after B's first grant → B holds 4 consecutive grants, then A gets one grant, then B resumes.
- Byte write then readback: B writes BE=4'b0010, DI=0xAABBCCDD to addr 0x020 (prior contents 0) → A read of 0x020 returns 0x0000_CC00.
- Reset mid-read: A read granted, RSTn=0 at the next edge → A_RVALID=0, all GNT=0, MEM_CSN=1 during reset. After release, the first B request is granted immediately with wait_b=0.
- Idle: no requests for 10 cycles → MEM_CSN=1, MEM_ADDR=0, no RVALID, counters remain 0.
